// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads one byte per cycle
// from a combinational instruction memory, resolves unconditional jumps
// locally and presents all other instructions to decode via a registered
// valid/ready output stage. A jump to itself parks the unit in HALT.
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC          = 8'h00,
    parameter bit         HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] Read_Address,
    input  logic [7:0] Instruction,
    output logic [7:0] out_instr,
    output logic [7:0] out_pc,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_addr,
    output logic       halted,
    output logic [7:0] jump_count
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    localparam logic [1:0] OP_JUMP = 2'b11;

    state_t     state, state_n;
    logic [7:0] pc, pc_n;
    logic [7:0] out_instr_n;
    logic [7:0] out_pc_n;
    logic       out_valid_n;
    logic [7:0] jump_count_n;

    logic       slot_free;
    logic       is_jump;
    logic [7:0] jump_target;

    assign Read_Address = pc;
    assign halted       = (state == HALT);

    // The output slot can take a new instruction when empty or being drained.
    assign slot_free   = !out_valid || out_ready;
    assign is_jump     = (Instruction[7:6] == OP_JUMP);
    // Offset is a 2-bit signed value relative to pc + 1; the sum wraps mod 256.
    assign jump_target = pc + 8'd1 + {{6{Instruction[1]}}, Instruction[1:0]};

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_n      = state;
        pc_n         = pc;
        out_instr_n  = out_instr;
        out_pc_n     = out_pc;
        out_valid_n  = out_valid;
        jump_count_n = jump_count;

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    // Flush: any held instruction is dropped, fetch restarts.
                    pc_n        = redirect_addr;
                    out_valid_n = 1'b0;
                end else if (slot_free) begin
                    if (is_jump) begin
                        // Jumps are consumed here and leave a one-cycle bubble.
                        out_valid_n  = 1'b0;
                        jump_count_n = jump_count + 8'd1;
                        if (HALT_ON_SELF_JUMP && (jump_target == pc)) begin
                            state_n = HALT;
                        end else begin
                            pc_n = jump_target;
                        end
                    end else begin
                        out_instr_n = Instruction;
                        out_pc_n    = pc;
                        out_valid_n = 1'b1;
                        pc_n        = pc + 8'd1;
                    end
                end
                // slot_free == 0: everything holds until decode accepts.
            end
            HALT: begin
                // The output slot is always empty here; only a redirect wakes us.
                out_valid_n = 1'b0;
                if (redirect_valid) begin
                    pc_n    = redirect_addr;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            out_instr  <= 8'h00;
            out_pc     <= 8'h00;
            out_valid  <= 1'b0;
            jump_count <= 8'h00;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            out_instr  <= out_instr_n;
            out_pc     <= out_pc_n;
            out_valid  <= out_valid_n;
            jump_count <= jump_count_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. A behavioural byte memory answers
// Read_Address combinationally; outputs are sampled 1 time unit after each
// rising edge, and inputs are changed at that same point.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Read_Address;
    logic [7:0] Instruction;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_valid;
    logic       out_ready;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       halted;
    logic [7:0] jump_count;

    logic [7:0] mem [256];

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch_unit #(
        .RESET_PC(8'h00),
        .HALT_ON_SELF_JUMP(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Read_Address(Read_Address),
        .Instruction(Instruction),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .halted(halted),
        .jump_count(jump_count)
    );

    assign Instruction = mem[Read_Address];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_pc, input logic [7:0] exp_instr);
        check({tag, " valid"}, {7'b0, out_valid}, 8'd1);
        check({tag, " pc"}, out_pc, exp_pc);
        check({tag, " instr"}, out_instr, exp_instr);
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h44;
        mem[1] = 8'h49;
        mem[2] = 8'h18;
        mem[3] = 8'h89;
        mem[4] = 8'hC2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        load_program();

        // ---- Reset state ----
        do_reset();
        check("rst valid", {7'b0, out_valid}, 8'd0);
        check("rst instr", out_instr, 8'h00);
        check("rst pc", out_pc, 8'h00);
        check("rst halted", {7'b0, halted}, 8'd0);
        check("rst jc", jump_count, 8'h00);
        check("rst addr", Read_Address, 8'h00);

        // ---- Straight-line fetch, then jump loop at 4 -> 3 ----
        tick(); check_out("p1 c1", 8'h00, 8'h44);
        tick(); check_out("p1 c2", 8'h01, 8'h49);
        tick(); check_out("p1 c3", 8'h02, 8'h18);
        tick(); check_out("p1 c4", 8'h03, 8'h89);
        tick();
        check("p1 c5 valid", {7'b0, out_valid}, 8'd0);
        check("p1 c5 jc", jump_count, 8'd1);
        check("p1 c5 addr", Read_Address, 8'h03);
        tick(); check_out("p1 c6", 8'h03, 8'h89);
        tick();
        check("p1 c7 valid", {7'b0, out_valid}, 8'd0);
        check("p1 c7 jc", jump_count, 8'd2);
        tick(); check_out("p1 c8", 8'h03, 8'h89);
        tick(); check("p1 c9 jc", jump_count, 8'd3);

        // ---- Back-pressure: out_ready low during cycles 2..5 ----
        do_reset();
        tick(); check_out("p2 c1", 8'h00, 8'h44);
        tick(); check_out("p2 c2", 8'h01, 8'h49);
        out_ready = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            tick();
            check_out("p2 stall", 8'h01, 8'h49);
            check("p2 stall addr", Read_Address, 8'h02);
        end
        tick();
        out_ready = 1'b1;
        check_out("p2 c6", 8'h01, 8'h49);
        tick(); check_out("p2 c7", 8'h02, 8'h18);
        tick(); check_out("p2 c8", 8'h03, 8'h89);

        // ---- Self-jump halt and redirect wake-up ----
        mem[7] = 8'hC3;
        do_reset();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h07;
        tick();
        redirect_valid = 1'b0;
        check("p3 redir addr", Read_Address, 8'h07);
        tick();
        check("p3 halted", {7'b0, halted}, 8'd1);
        check("p3 halt valid", {7'b0, out_valid}, 8'd0);
        check("p3 halt jc", jump_count, 8'd1);
        tick(); tick(); tick();
        check("p3 still halted", {7'b0, halted}, 8'd1);
        check("p3 frozen addr", Read_Address, 8'h07);
        check("p3 frozen jc", jump_count, 8'd1);
        check("p3 frozen valid", {7'b0, out_valid}, 8'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h00;
        tick();
        redirect_valid = 1'b0;
        check("p3 wake halted", {7'b0, halted}, 8'd0);
        check("p3 wake addr", Read_Address, 8'h00);
        tick(); check_out("p3 resume", 8'h00, 8'h44);

        // ---- Address wrap: jump target and sequential fetch ----
        mem[8'hFF] = 8'hC0;
        mem[1]     = 8'h44;
        do_reset();
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("p4 jump valid", {7'b0, out_valid}, 8'd0);
        check("p4 jump target", Read_Address, 8'h00);
        check("p4 jump jc", jump_count, 8'd1);
        tick(); check_out("p4 after jump", 8'h00, 8'h44);
        mem[8'hFF] = 8'h12;
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_out("p4 seq FF", 8'hFF, 8'h12);
        check("p4 seq wrap addr", Read_Address, 8'h00);
        tick(); check_out("p4 seq 00", 8'h00, 8'h44);
        tick(); check_out("p4 seq 01", 8'h01, 8'h44);

        // ---- Redirect while a stalled instruction is held ----
        out_ready = 1'b0;
        tick();
        check_out("p5 held", 8'h01, 8'h44);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("p5 flush valid", {7'b0, out_valid}, 8'd0);
        check("p5 flush addr", Read_Address, 8'h20);

        // ---- Reset mid-stream with a valid output ----
        tick();
        check_out("p6 pre", 8'h20, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("p6 valid", {7'b0, out_valid}, 8'd0);
        check("p6 instr", out_instr, 8'h00);
        check("p6 pc", out_pc, 8'h00);
        check("p6 halted", {7'b0, halted}, 8'd0);
        check("p6 jc", jump_count, 8'h00);
        check("p6 addr", Read_Address, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
